// File: rtl/rv32_m_pkg.sv
// Shared definitions for the RV32 M-extension execute units: op encodings,
// divider state encoding and the default datapath width.
package rv32_m_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } div_state_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/rv32_iter_divider_if.sv
// Issue/writeback handshake bundle for the iterative divider.
interface rv32_iter_divider_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, dividend, divisor, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, dividend, divisor, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/div_trial_sub.sv
// Trial subtractor a - b built as a + ~b + 1 on a Kogge-Stone carry tree.
// nonneg_o is the carry out, i.e. a >= b as unsigned.
module div_trial_sub #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         nonneg_o
);
    logic [W-1:0] p;
    logic [W-1:0] gg;
    logic [W-1:0] pp;
    logic [W-1:0] carry;

    always_comb begin
        p  = a_i ^ ~b_i;
        gg = a_i & ~b_i;
        pp = p;
        // Carry-in of 1 folded into bit 0's generate
        gg[0] = gg[0] | pp[0];
        for (int d = 1; d < int'(W); d = d * 2) begin
            // Descending order keeps gg/pp[i-d] at the previous tree level
            for (int i = int'(W) - 1; i >= d; i--) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        carry    = {gg[W-2:0], 1'b1};
        diff_o   = p ^ carry;
        nonneg_o = gg[W-1];
    end

endmodule

// File: rtl/rv32_iter_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with single-cycle handling of divide-by-zero and signed overflow.
module rv32_iter_divider
    import rv32_m_pkg::*;
#(
    parameter int unsigned XLEN = rv32_m_pkg::XLEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    rv32_iter_divider_if.slave  bus
);
    localparam int unsigned CntW = $clog2(XLEN);

    div_state_e      state_q, state_d;
    logic [XLEN-1:0] dq_q, dq_d;      // dividend, shifted out MSB-first as quotient shifts in
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            is_rem_q, is_rem_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            in_signed;
    logic            in_rem;
    logic            sign_a;
    logic            sign_b;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            div_zero;
    logic            sgn_ovf;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   trial_diff;
    logic            trial_nonneg;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rmd_fix;
    logic            unused_rem_msb;

    assign in_signed = op_is_signed(bus.op);
    assign in_rem    = op_is_rem(bus.op);
    assign sign_a    = in_signed & bus.dividend[XLEN-1];
    assign sign_b    = in_signed & bus.divisor[XLEN-1];
    assign abs_a     = sign_a ? (~bus.dividend + XLEN'(1)) : bus.dividend;
    assign abs_b     = sign_b ? (~bus.divisor + XLEN'(1)) : bus.divisor;
    assign div_zero  = (bus.divisor == '0);
    assign sgn_ovf   = in_signed && (bus.dividend == {1'b1, {(XLEN-1){1'b0}}})
                       && (bus.divisor == '1);

    // Remainder stays below the divisor, so its top bit is always zero once stored
    assign rem_shift      = {rem_q[XLEN-1:0], dq_q[XLEN-1]};
    assign unused_rem_msb = rem_q[XLEN];

    div_trial_sub #(
        .W(XLEN + 1)
    ) u_trial_sub (
        .a_i      (rem_shift),
        .b_i      ({1'b0, dvs_q}),
        .diff_o   (trial_diff),
        .nonneg_o (trial_nonneg)
    );

    assign quo_fix = q_neg_q ? (~dq_q + XLEN'(1)) : dq_q;
    assign rmd_fix = r_neg_q ? (~rem_q[XLEN-1:0] + XLEN'(1)) : rem_q[XLEN-1:0];

    always_comb begin
        state_d  = state_q;
        dq_d     = dq_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        is_rem_d = is_rem_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && !flush) begin
                    if (div_zero) begin
                        result_d = in_rem ? bus.dividend : '1;
                        state_d  = StDone;
                    end else if (sgn_ovf) begin
                        result_d = in_rem ? '0 : bus.dividend;
                        state_d  = StDone;
                    end else begin
                        dq_d     = abs_a;
                        dvs_d    = abs_b;
                        rem_d    = '0;
                        cnt_d    = '0;
                        q_neg_d  = sign_a ^ sign_b;
                        r_neg_d  = sign_a;
                        is_rem_d = in_rem;
                        state_d  = StCalc;
                    end
                end
            end
            StCalc: begin
                rem_d = trial_nonneg ? trial_diff : rem_shift;
                dq_d  = {dq_q[XLEN-2:0], trial_nonneg};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(XLEN - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                result_d = is_rem_q ? rmd_fix : quo_fix;
                state_d  = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            dq_q     <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            is_rem_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            dq_q     <= dq_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            is_rem_q <= is_rem_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;

endmodule

// File: tb/tb_rv32_iter_divider.sv
// Randomised self-checking bench for rv32_iter_divider against a plain-arithmetic
// model of RISC-V division semantics, plus directed corner cases.
module tb_rv32_iter_divider;
    import rv32_m_pkg::*;

    localparam int unsigned W = 32;
    localparam int LatNorm = W + 2;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    rv32_iter_divider_if #(.XLEN(W)) bus ();

    rv32_iter_divider #(
        .XLEN(W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   cur_valid = 1'b0;
    bit   drop_chk  = 1'b0;
    int   checks    = 0;
    int   errors    = 0;
    int   edge_cnt  = 0;
    int   rdy_mode  = 0;
    logic rdy_man   = 1'b1;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(posedge clk) begin
        #1;
        bus.out_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : rdy_man;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: RISC-V M semantics from plain arithmetic
    function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0] q;
        logic [31:0] r;
        bit          sgn;
        sa  = a;
        sb  = b;
        sgn = (o == DIV_OP_DIV) || (o == DIV_OP_REM);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 32'd0;
        end else if (sgn) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return ((o == DIV_OP_REM) || (o == DIV_OP_REMU)) ? r : q;
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
        bit sgn;
        sgn = (o == DIV_OP_DIV) || (o == DIV_OP_REM);
        if (b == 32'd0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return LatNorm;
    endfunction

    // Compare process: every cycle with out_valid high is checked
    always @(negedge clk) begin
        if (drop_chk) begin
            chk("out_valid_drop", bus.out_valid, 1'b0);
            drop_chk = 1'b0;
        end
        if (bus.out_valid) begin
            if (!cur_valid) begin
                chk("pending_txn", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    cur       = exp_q.pop_front();
                    cur_valid = 1'b1;
                    chk("latency", edge_cnt - cur.acc + 1, cur.lat);
                    chk("result", bus.result, cur.res);
                end
            end else begin
                chk("result_hold", bus.result, cur.res);
            end
            chk("in_ready_busy", bus.in_ready, 1'b0);
            if (bus.out_ready || rst || flush) begin
                cur_valid = 1'b0;
                drop_chk  = 1'b1;
            end
        end
        if (rst || flush) begin
            exp_q.delete();
            cur_valid = 1'b0;
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input int lat);
        int n;
        n = 0;
        @(negedge clk);
        bus.op       = o;
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("accept", bus.in_ready, 1'b1);
        if (bus.in_ready) begin
            exp_q.push_back('{res, lat, edge_cnt + 1});
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cur_valid || drop_chk) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", (exp_q.size() == 0) && !cur_valid, 1'b1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int          n;

        rst          = 1'b1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.op       = 2'b00;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_result", bus.result, 32'd0);

        // Pin the model against hand-computed values
        chk("model_divu", model_res(DIV_OP_DIVU, 32'd100, 32'd7), 32'd14);
        chk("model_rem_neg", model_res(DIV_OP_REM, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        chk("model_div0", model_res(DIV_OP_DIV, 32'd5, 32'd0), 32'hFFFF_FFFF);
        chk("model_ovf", model_res(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        // Directed cases with literal expectations
        issue(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 34);                   wait_done();
        issue(DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 34);                    wait_done();
        issue(DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);        wait_done();
        issue(DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);        wait_done();
        issue(DIV_OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);                wait_done();
        issue(DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);                 wait_done();
        issue(DIV_OP_REMU, 32'd5, 32'd0, 32'd5, 1);                        wait_done();
        issue(DIV_OP_DIVU, 32'd0, 32'd0, 32'hFFFF_FFFF, 1);                wait_done();
        issue(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1); wait_done();
        issue(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);         wait_done();

        // Backpressure: out_ready held low while DONE
        rdy_man = 1'b0;
        issue(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", bus.out_valid, 1'b1);
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk("bp_result", bus.result, 32'd14);
        end
        rdy_man = 1'b1;
        wait_done();

        // Flush during CALC
        issue(DIV_OP_DIVU, 32'd1000, 32'd3, 32'd333, 34);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", bus.in_ready, 1'b1);
        chk("flush_out_valid", bus.out_valid, 1'b0);
        chk("flush_keeps_result", bus.result, 32'd14);
        repeat (40) @(negedge clk);

        // A request alongside flush in IDLE is dropped
        @(posedge clk);
        #1;
        flush        = 1'b1;
        bus.op       = DIV_OP_DIV;
        bus.divisor  = 32'd0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_req_dropped", bus.in_ready, 1'b1);
        repeat (3) @(negedge clk);

        issue(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 34);
        wait_done();

        // Reset during CALC
        issue(DIV_OP_DIVU, 32'd1000, 32'd3, 32'd333, 34);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_ready", bus.in_ready, 1'b1);
        chk("rst_mid_out_valid", bus.out_valid, 1'b0);
        chk("rst_mid_result", bus.result, 32'd0);
        repeat (40) @(negedge clk);
        issue(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 34);
        wait_done();

        // Random operations with random backpressure
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            o = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            issue(o, a, b, model_res(o, a, b), model_lat(o, a, b));
            wait_done();
        end
        rdy_mode = 0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
